// File: rtl/dsc_mul_n.sv
// Deterministic stochastic-computing multiplier/combiner: one unary SNG per operand,
// the SNGs chained by rollover enables so every counter combination is visited exactly once.
module dsc_mul_n #(
  parameter int SNG_WIDTH  = 4,
  parameter int NUM_INPUTS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            op,
  input  logic [NUM_INPUTS*SNG_WIDTH-1:0] operands,
  output logic                            busy,
  output logic                            done,
  output logic [NUM_INPUTS*SNG_WIDTH-1:0] z
);

  localparam int W  = SNG_WIDTH;
  localparam int N  = NUM_INPUTS;
  localparam int ZW = N * W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_reg;
  logic [N-1:0][W-1:0]   opnd_reg;
  logic [N-1:0][W-1:0]   ctr_reg;
  logic                  op_reg;
  logic [ZW-1:0]         z_reg;
  logic [ZW-1:0]         run_cnt_reg;
  logic                  busy_reg;
  logic                  done_reg;

  logic [N-1:0]          stream;
  logic [N-1:0]          carry;
  logic [N-1:0]          opnd_zero;
  logic                  m;

  // carry[i] is the rollover enable of SNG i: all lower counters are at their maximum
  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_sng
      assign stream[gi]    = opnd_reg[gi] > ctr_reg[gi];
      assign opnd_zero[gi] = (operands[gi*W +: W] == '0);
      if (gi > 0) begin : g_carry
        assign carry[gi] = carry[gi-1] & (ctr_reg[gi-1] == {W{1'b1}});
      end
    end
  endgenerate

  assign m = op_reg ? (|stream) : (&stream);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      opnd_reg    <= '0;
      ctr_reg     <= '0;
      op_reg      <= 1'b0;
      z_reg       <= '0;
      run_cnt_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            opnd_reg    <= operands;
            op_reg      <= op;
            ctr_reg     <= '0;
            z_reg       <= '0;
            run_cnt_reg <= '0;
            // A zero factor makes the AND product zero, so skip the run entirely
            if (!op && (|opnd_zero)) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= RUN;
              busy_reg  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (m) z_reg <= z_reg + ZW'(1);
          run_cnt_reg <= run_cnt_reg + ZW'(1);
          for (int i = 0; i < N; i++) begin
            if (carry[i]) ctr_reg[i] <= ctr_reg[i] + W'(1);
          end
          if (run_cnt_reg == {ZW{1'b1}}) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign z    = z_reg;

endmodule

// File: tb/tb_dsc_mul_n.sv
// Directed bench: 4 operands x 2 bits (T=256) main instance plus a 2 x 3-bit (T=64) instance.
module tb_dsc_mul_n;

  localparam int LIMIT = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic [7:0] operands = '0;
  logic       busy;
  logic       done;
  logic [7:0] z;

  logic       start2 = 1'b0;
  logic       op2 = 1'b0;
  logic [5:0] operands2 = '0;
  logic       busy2;
  logic       done2;
  logic [5:0] z2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dsc_mul_n #(.SNG_WIDTH(2), .NUM_INPUTS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .operands(operands),
    .busy(busy), .done(done), .z(z)
  );

  dsc_mul_n #(.SNG_WIDTH(3), .NUM_INPUTS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .op(op2), .operands(operands2),
    .busy(busy2), .done(done2), .z(z2)
  );

  // Launch one operation on the main instance and measure latency and busy cycles.
  task automatic do_op(input logic o, input logic [7:0] opnds, output int lat, output int bcnt);
    @(posedge clk); #1;
    op = o; operands = opnds; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; bcnt = 0;
    while (done !== 1'b1 && lat < LIMIT) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    $display("op=%0d operands=%h z=%0d lat=%0d busy_cycles=%0d", o, opnds, z, lat, bcnt);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #12;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (z !== 8'd0) begin bad++; $display("FAIL reset_z: got %0d want 0", z); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_and;
    int lat, bcnt;
    do_op(1'b0, 8'hB9, lat, bcnt);  // a=1 b=2 c=3 d=2
    total++; if (z !== 8'd12) begin bad++; $display("FAIL and_1232_z: got %0d want 12", z); end
    total++; if (lat != 257) begin bad++; $display("FAIL and_latency: got %0d want 257", lat); end
    total++; if (bcnt != 256) begin bad++; $display("FAIL and_busy_cycles: got %0d want 256", bcnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL and_busy_at_done: got %b want 0", busy); end
    repeat (5) @(posedge clk);
    #1;
    total++; if (z !== 8'd12) begin bad++; $display("FAIL and_z_hold: got %0d want 12", z); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL and_done_pulse: got %b want 0", done); end
    do_op(1'b0, 8'hFF, lat, bcnt);
    total++; if (z !== 8'd81) begin bad++; $display("FAIL and_all3_z: got %0d want 81", z); end
  endtask

  task automatic test_or;
    int lat, bcnt;
    do_op(1'b1, 8'h55, lat, bcnt);
    total++; if (z !== 8'd175) begin bad++; $display("FAIL or_all1_z: got %0d want 175", z); end
    total++; if (lat != 257) begin bad++; $display("FAIL or_latency: got %0d want 257", lat); end
    do_op(1'b1, 8'hFF, lat, bcnt);
    total++; if (z !== 8'd255) begin bad++; $display("FAIL or_all3_z: got %0d want 255", z); end
    do_op(1'b1, 8'h00, lat, bcnt);
    total++; if (z !== 8'd0) begin bad++; $display("FAIL or_all0_z: got %0d want 0", z); end
    total++; if (bcnt != 256) begin bad++; $display("FAIL or_all0_busy: got %0d want 256", bcnt); end
  endtask

  task automatic test_short_circuit;
    int lat, bcnt;
    do_op(1'b0, 8'hF3, lat, bcnt);  // b=0
    total++; if (lat != 1) begin bad++; $display("FAIL sc_latency: got %0d want 1", lat); end
    total++; if (bcnt != 0) begin bad++; $display("FAIL sc_busy: got %0d want 0", bcnt); end
    total++; if (z !== 8'd0) begin bad++; $display("FAIL sc_z: got %0d want 0", z); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL sc_done_once: got %b want 0", done); end
    do_op(1'b1, 8'hF3, lat, bcnt);
    total++; if (z !== 8'd252) begin bad++; $display("FAIL sc_or_z: got %0d want 252", z); end
    total++; if (lat != 257) begin bad++; $display("FAIL sc_or_latency: got %0d want 257", lat); end
  endtask

  task automatic test_midrun_start;
    int lat;
    @(posedge clk); #1;
    op = 1'b0; operands = 8'hDB; start = 1'b1;  // a=3 b=2 c=1 d=3
    @(posedge clk); #1;
    start = 1'b0; lat = 1;
    repeat (50) begin @(posedge clk); #1; lat++; end
    op = 1'b1; operands = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat++;
    while (done !== 1'b1 && lat < LIMIT) begin @(posedge clk); #1; lat++; end
    $display("midrun restart ignored: z=%0d lat=%0d", z, lat);
    total++; if (z !== 8'd18) begin bad++; $display("FAIL midrun_z: got %0d want 18", z); end
    total++; if (lat != 257) begin bad++; $display("FAIL midrun_latency: got %0d want 257", lat); end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(posedge clk); #1;
    op = 1'b0; operands = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (done !== 1'b1 && lat < LIMIT) begin @(posedge clk); #1; lat++; end
    $display("held start first op: z=%0d lat=%0d", z, lat);
    total++; if (z !== 8'd81) begin bad++; $display("FAIL b2b_first_z: got %0d want 81", z); end
    operands = 8'hAA;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_done_ignores_start: busy got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_idle_done: got %b want 0", done); end
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_second_start: busy got %b want 1", busy); end
    total++; if (z !== 8'd0) begin bad++; $display("FAIL b2b_z_cleared: got %0d want 0", z); end
    lat = 1;
    while (done !== 1'b1 && lat < LIMIT) begin @(posedge clk); #1; lat++; end
    $display("held start second op: z=%0d lat=%0d", z, lat);
    total++; if (z !== 8'd16) begin bad++; $display("FAIL b2b_second_z: got %0d want 16", z); end
    total++; if (lat != 257) begin bad++; $display("FAIL b2b_second_latency: got %0d want 257", lat); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_no_third: busy got %b want 0", busy); end
  endtask

  task automatic test_async_reset;
    int lat, bcnt;
    @(posedge clk); #1;
    op = 1'b0; operands = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL arst_pre_busy: got %b want 1", busy); end
    #2;
    rst = 1'b0;
    #1;
    $display("async reset mid-run: z=%0d busy=%b done=%b", z, busy, done);
    total++; if (z !== 8'd0) begin bad++; $display("FAIL arst_z: got %0d want 0", z); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL arst_done: got %b want 0", done); end
    @(posedge clk); #1;
    rst = 1'b1;
    do_op(1'b0, 8'hAA, lat, bcnt);
    total++; if (z !== 8'd16) begin bad++; $display("FAIL arst_after_z: got %0d want 16", z); end
    total++; if (lat != 257) begin bad++; $display("FAIL arst_after_latency: got %0d want 257", lat); end
  endtask

  task automatic test_override;
    int lat;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      op2 = k[0]; operands2 = {3'd6, 3'd5}; start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0; lat = 1;
      while (done2 !== 1'b1 && lat < LIMIT) begin @(posedge clk); #1; lat++; end
      $display("override op=%0d operands=5,6 z=%0d lat=%0d", k, z2, lat);
      total++; if (lat != 65) begin bad++; $display("FAIL ovr_latency op%0d: got %0d want 65", k, lat); end
      if (k == 0) begin
        total++; if (z2 !== 6'd30) begin bad++; $display("FAIL ovr_and_z: got %0d want 30", z2); end
      end else begin
        total++; if (z2 !== 6'd58) begin bad++; $display("FAIL ovr_or_z: got %0d want 58", z2); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_and();
    test_or();
    test_short_circuit();
    test_midrun_start();
    test_back_to_back();
    test_async_reset();
    test_override();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
